// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM encoding, frame geometry and default line timing.
package uart_pkg;

   localparam int unsigned DEF_CLK_FREQ = 50_000_000;
   localparam int unsigned DEF_BAUD     = 9600;
   localparam int unsigned FRAME_BITS   = 10;
   localparam int unsigned DATA_BITS    = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_e;

   // Clocks per bit; integer division, so the line rate rounds slightly fast.
   function automatic int unsigned bps_cnt(input int unsigned clk_freq, input int unsigned baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART transmitter; flags and level are registered together.
module uart_tx_fifo #(
   parameter  int unsigned FIFO_DEPTH = 4,
   localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [7:0]       wdata,
   output logic [7:0]       rdata,
   output logic [LVL_W-1:0] level,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [LVL_W-1:0] level_q;
   logic [LVL_W-1:0] level_d;
   logic             full_q;
   logic             empty_q;
   logic             push_ok;
   logic             pop_ok;

   // A write into a full FIFO is dropped even if a pop happens in the same cycle.
   assign push_ok = push && !full_q;
   assign pop_ok  = pop && !empty_q;

   always_comb begin
      level_d = level_q;
      case ({push_ok, pop_ok})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         level_q <= level_d;
         full_q  <= (level_d == LVL_W'(FIFO_DEPTH));
         empty_q <= (level_d == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= wdata;
   end

   assign rdata = mem[rd_ptr_q];
   assign level = level_q;
   assign full  = full_q;
   assign empty = empty_q;

endmodule

// File: rtl/uart_tx_engine.sv
// Buffered 8N1 UART transmitter with its own baud counter; bytes arrive over valid/ready.
module uart_tx_engine
   import uart_pkg::*;
#(
   parameter  int unsigned CLK_FREQ   = DEF_CLK_FREQ,
   parameter  int unsigned BAUD       = DEF_BAUD,
   parameter  int unsigned FIFO_DEPTH = 4,
   localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic             CLK_50M,
   input  logic             RST_N,
   input  logic [7:0]       tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             UART_TX,
   output logic             tx_busy,
   output logic [LVL_W-1:0] fifo_level
);

   localparam int unsigned BPS_CNT = bps_cnt(CLK_FREQ, BAUD);
   localparam int unsigned CNT_W   = $clog2(BPS_CNT);
   localparam int unsigned BIT_W   = $clog2(DATA_BITS);

   tx_state_e              state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [BIT_W-1:0]       bit_idx_q;
   logic [DATA_BITS-1:0]   shift_q;
   logic                   tx_q;
   logic                   busy_q;
   logic                   line_c;
   logic                   bit_end;
   logic                   fifo_pop;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [7:0]             fifo_rdata;

   uart_tx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (CLK_50M),
      .rst_n (RST_N),
      .push  (tx_valid),
      .pop   (fifo_pop),
      .wdata (tx_data),
      .rdata (fifo_rdata),
      .level (fifo_level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign bit_end = (cnt_q == CNT_W'(BPS_CNT - 1));

   // Head is taken when leaving IDLE or at the end of a stop bit, so frames chain with no gap.
   assign fifo_pop = !fifo_empty &&
                     ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end));

   always_comb begin
      line_c = 1'b1;
      case (state_q)
         ST_START: line_c = 1'b0;
         ST_DATA:  line_c = shift_q[0];
         default:  line_c = 1'b1;
      endcase
   end

   // Line and busy both follow the state one flop later, keeping them mutually consistent.
   always_ff @(posedge CLK_50M or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         tx_q   <= line_c;
         busy_q <= (state_q != ST_IDLE) || (fifo_level != '0);
         case (state_q)
            ST_IDLE: begin
               cnt_q <= '0;
               if (!fifo_empty) begin
                  shift_q <= fifo_rdata;
                  state_q <= ST_START;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  cnt_q     <= '0;
                  bit_idx_q <= '0;
                  state_q   <= ST_DATA;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  cnt_q   <= '0;
                  shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
                  if (bit_idx_q == BIT_W'(DATA_BITS - 1)) begin
                     state_q <= ST_STOP;
                  end else begin
                     bit_idx_q <= bit_idx_q + BIT_W'(1);
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_STOP: begin
               if (bit_end) begin
                  cnt_q <= '0;
                  if (!fifo_empty) begin
                     shift_q <= fifo_rdata;
                     state_q <= ST_START;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign tx_ready = ~fifo_full;
   assign UART_TX  = tx_q;
   assign tx_busy  = busy_q;

endmodule
